// File: rtl/multi_reg_sequencer.sv
// -----------------------------------------------------------------------------
// multi_reg_sequencer
//
// Sequences multi-register transfers (LDM/STM/PUSH/POP) between the register
// file and the data-memory port. The latched register list is walked from the
// lowest set bit to the highest, one register per memory beat. Stores read
// each register through RA/RDATA; loads write through port 1 (WEN1/WA1/DI1).
// A load of R15 is steered to the PC instead of port 1. At the end, the
// optional base writeback uses port 2 (WEN2/WA2/DI2).
//
// Ports
//   CLK, nRST           clock, asynchronous active-low reset
//   START               one-cycle request, accepted only while BUSY=0
//   LOAD/DECR/WBACK     direction, descending mode, base writeback enable
//   RLIST/BASE/BASE_REG register list, base address, base register index
//   BUSY/DONE           busy flag, one-cycle completion pulse
//   MREQ/MWRITE/MADDR   memory request, write flag, word address
//   MWDATA/MRDATA       store data (= RDATA), load data
//   MREADY              beat complete this cycle
//   RA/RDATA            regfile read port
//   WEN1/WA1/DI1        regfile write port 1 (load data)
//   WEN2/WA2/DI2        regfile write port 2 (base writeback)
//   PC_WEN/PC_DATA      PC load for a load of R15
// -----------------------------------------------------------------------------
module multi_reg_sequencer (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        START,
   input  logic        LOAD,
   input  logic        DECR,
   input  logic        WBACK,
   input  logic [15:0] RLIST,
   input  logic [31:0] BASE,
   input  logic [3:0]  BASE_REG,
   output logic        BUSY,
   output logic        DONE,
   output logic        MREQ,
   output logic        MWRITE,
   output logic [31:0] MADDR,
   output logic [31:0] MWDATA,
   input  logic [31:0] MRDATA,
   input  logic        MREADY,
   output logic [3:0]  RA,
   input  logic [31:0] RDATA,
   output logic        WEN1,
   output logic [3:0]  WA1,
   output logic [31:0] DI1,
   output logic        WEN2,
   output logic [3:0]  WA2,
   output logic [31:0] DI2,
   output logic        PC_WEN,
   output logic [31:0] PC_DATA
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_XFER = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   state_t      r_state;
   logic        r_load;
   logic        r_wback;
   logic        r_base_in_list;
   logic [3:0]  r_base_reg;
   logic [15:0] r_list;
   logic [31:0] r_final;
   logic [31:0] r_addr;
   logic        r_mreq;
   logic        r_mwrite;
   logic [3:0]  r_ra;
   logic        r_done;
   logic        r_wen2;
   logic [3:0]  r_wa2;
   logic [31:0] r_di2;

   logic [15:0] w_list_in;
   logic [4:0]  w_cnt;
   logic [31:0] w_four_cnt;
   logic [31:0] w_base_dn;
   logic [31:0] w_start_addr;
   logic [31:0] w_final;
   logic [15:0] w_list_next;
   logic        w_beat;
   logic        w_wen1;
   logic        w_pc_wen;

   function automatic logic [4:0] f_popcount(input logic [15:0] l);
      logic [4:0] c;
      c = '0;
      for (int i = 0; i < 16; i++) c = c + {4'b0000, l[i]};
      return c;
   endfunction

   // Scanning from the top lets the last hit be the lowest set bit.
   function automatic logic [3:0] f_lowest(input logic [15:0] l);
      logic [3:0] idx;
      idx = '0;
      for (int i = 15; i >= 0; i--) if (l[i]) idx = 4'(i);
      return idx;
   endfunction

   // A store never transfers R15.
   assign w_list_in    = LOAD ? RLIST : {1'b0, RLIST[14:0]};
   assign w_cnt        = f_popcount(w_list_in);
   assign w_four_cnt   = {25'd0, w_cnt, 2'b00};
   assign w_base_dn    = BASE - w_four_cnt;
   assign w_start_addr = (DECR ? w_base_dn : BASE) & 32'hFFFF_FFFC;
   assign w_final      = (DECR ? w_base_dn : BASE + w_four_cnt) & 32'hFFFF_FFFC;

   assign w_list_next  = r_list & ~(16'h0001 << r_ra);
   assign w_beat       = (r_state == S_XFER) && MREADY;
   assign w_wen1       = w_beat && r_load && (r_ra != 4'hF);
   assign w_pc_wen     = w_beat && r_load && (r_ra == 4'hF);

   assign BUSY    = (r_state != S_IDLE);
   assign DONE    = r_done;
   assign MREQ    = r_mreq;
   assign MWRITE  = r_mwrite;
   assign MADDR   = r_addr;
   assign RA      = r_ra;
   assign MWDATA  = RDATA;
   // Load-side outputs are gated so they read zero whenever no write is made.
   assign WEN1    = w_wen1;
   assign WA1     = w_wen1 ? r_ra : 4'h0;
   assign DI1     = w_wen1 ? MRDATA : 32'h0;
   assign PC_WEN  = w_pc_wen;
   assign PC_DATA = w_pc_wen ? MRDATA : 32'h0;
   assign WEN2    = r_wen2;
   assign WA2     = r_wa2;
   assign DI2     = r_di2;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state        <= S_IDLE;
         r_load         <= 1'b0;
         r_wback        <= 1'b0;
         r_base_in_list <= 1'b0;
         r_base_reg     <= 4'h0;
         r_list         <= 16'h0;
         r_final        <= 32'h0;
         r_addr         <= 32'h0;
         r_mreq         <= 1'b0;
         r_mwrite       <= 1'b0;
         r_ra           <= 4'h0;
         r_done         <= 1'b0;
         r_wen2         <= 1'b0;
         r_wa2          <= 4'h0;
         r_di2          <= 32'h0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               r_wen2 <= 1'b0;
               if (START) begin
                  r_load         <= LOAD;
                  r_wback        <= WBACK;
                  r_base_reg     <= BASE_REG;
                  r_base_in_list <= w_list_in[BASE_REG];
                  r_final        <= w_final;
                  r_list         <= w_list_in;
                  r_addr         <= w_start_addr;
                  if (w_list_in != 16'h0) begin
                     r_state  <= S_XFER;
                     r_mreq   <= 1'b1;
                     r_mwrite <= ~LOAD;
                     r_ra     <= f_lowest(w_list_in);
                  end else begin
                     // Empty list: completion pulse only, never a writeback.
                     r_state <= S_FIN;
                     r_done  <= 1'b1;
                  end
               end
            end

            S_XFER: begin
               // Request, address, direction and RA hold until MREADY.
               if (MREADY) begin
                  r_list <= w_list_next;
                  r_addr <= r_addr + 32'd4;
                  if (w_list_next == 16'h0) begin
                     r_state  <= S_FIN;
                     r_mreq   <= 1'b0;
                     r_mwrite <= 1'b0;
                     r_done   <= 1'b1;
                     // A loaded base register keeps its loaded value.
                     r_wen2   <= r_wback && !(r_load && r_base_in_list);
                     r_wa2    <= r_base_reg;
                     r_di2    <= r_final;
                  end else begin
                     r_ra <= f_lowest(w_list_next);
                  end
               end
            end

            S_FIN: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
               r_wen2  <= 1'b0;
            end

            default: begin
               r_state <= S_IDLE;
               r_mreq  <= 1'b0;
               r_done  <= 1'b0;
               r_wen2  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/multi_reg_sequencer.md
# multi_reg_sequencer

Drives the register file for multi-register transfers: LDM/STM/PUSH/POP. It walks a 16-bit register list from lowest to highest, one register per memory beat. Stores read registers through one regfile read port; loads write them back through write port 1. Base-register writeback goes through write port 2, and a POP of R15 is routed to the PC. It sits between the decode/execute control and the data-memory port, alongside the register file.

## Interface
- No parameters; the data path is fixed at 32 bits, with 16 list bits and 4-bit register addresses.
- CLK  in  1  clock; all state updates on the rising edge
- nRST  in  1  reset, asynchronous, active-low
- START  in  1  one-cycle request; accepted only while BUSY=0
- LOAD  in  1  1 = load (LDM/POP), 0 = store (STM/PUSH); sampled with START
- DECR  in  1  1 = descending (PUSH), 0 = ascending; sampled with START
- WBACK  in  1  base writeback enable; sampled with START
- RLIST  in  16  register list; bit n selects Rn; sampled with START
- BASE  in  32  base address value; sampled with START
- BASE_REG  in  4  base register index (0–14); sampled with START
- BUSY  out  1  high while the state is not IDLE
- DONE  out  1  one-cycle completion pulse
- MREQ  out  1  memory request, held until MREADY
- MWRITE  out  1  1 = write beat
- MADDR  out  32  word address; [1:0] always 0
- MWDATA  out  32  store data, equal to RDATA (combinational)
- MRDATA  in  32  load data, valid when MREADY=1
- MREADY  in  1  beat accepted/complete this cycle
- RA  out  4  regfile read address (to a DOUT port)
- RDATA  in  32  regfile read data (asynchronous read)
- WEN1/WA1/DI1  out  1/4/32  regfile write port 1 (load data)
- WEN2/WA2/DI2  out  1/4/32  regfile write port 2 (base writeback)
- PC_WEN/PC_DATA  out  1/32  PC load for a POP of R15

## Operation
- States: IDLE, XFER, FIN.
- IDLE:
  - START=1 latches all inputs. Bit 15 is cleared when LOAD=0.
  - CNT = popcount of the latched list. START_ADDR = DECR ? BASE−4·CNT : BASE. FINAL = DECR ? BASE−4·CNT : BASE+4·CNT. Arithmetic is 32-bit modulo 2^32, with the result's [1:0] forced to 0.
  - Non-empty list → XFER; empty list → FIN.
- XFER:
  - CUR = lowest set bit of the remaining list.
  - Registered outputs: MREQ=1, MWRITE=~LOAD, MADDR=current address, RA=CUR[3:0].
  - MREQ, MADDR, MWRITE and RA stay stable until MREADY=1.
  - On a cycle with MREADY=1:
    - Load with CUR<15: WEN1=1, WA1=CUR, DI1=MRDATA (combinational, same cycle).
    - Load with CUR=15: PC_WEN=1, PC_DATA=MRDATA; WEN1 stays 0.
    - Store: the memory captures MWDATA=RDATA.
    - Then CUR's bit is cleared and the address advances by 4, ascending in both modes.
    - If this was the last bit → FIN.
- FIN (one cycle):
  - DONE=1.
  - If WBACK=1, and not (LOAD=1 and BASE_REG is in the list): WEN2=1, WA2=BASE_REG, DI2=FINAL. In that excluded case the loaded value wins and there is no writeback.
  - Empty list: DONE only, with no writeback.
  - → IDLE.
- START while BUSY=1 is ignored; no queueing.
- WEN1 and WEN2 are never asserted in the same cycle.

## Timing
- Reset values (asynchronous, immediate): state=IDLE. BUSY, DONE, MREQ, MWRITE, WEN1, WEN2 and PC_WEN are all 0. MADDR, RA, WA1, WA2, DI1, DI2 and PC_DATA are all 0.
- Reset mid-transfer aborts at once: the in-flight request drops, no further regfile writes occur, and DONE does not pulse.
- START sampled at edge 0:
  - BUSY=1 and MREQ=1 (first beat) from cycle 1.
  - With MREADY tied high, beat k occupies cycle k (k = 1..CNT), DONE occurs at cycle CNT+1, and BUSY=0 from cycle CNT+2.
  - Each MREADY=0 cycle adds one cycle of latency.
  - Empty list: DONE at cycle 1, BUSY=0 at cycle 2.
- The next START is accepted in the first cycle with BUSY=0.
- Outside XFER: MREQ=0, and MADDR holds its last value.

## Test plan
- STM, RLIST=0x00A1 (R0,R5,R7), BASE=0x1000, DECR=0, WBACK=1, BASE_REG=1, MREADY=1 → writes to 0x1000/0x1004/0x1008 with R0/R5/R7 data; DONE at cycle 4 with WEN2, WA2=1, DI2=0x100C.
- PUSH {R4,LR}: RLIST=0x4010, BASE=0x00010000, DECR=1, BASE_REG=13 → R4 written to 0xFFF8 and R14 to 0xFFFC; DI2=0x0000FFF8.
- POP {R0,PC}: RLIST=0x8001, BASE=0xFFF8, memory returns 0x11 then 0x200 → WEN1 WA1=0 DI1=0x11, then PC_WEN with PC_DATA=0x200 and WEN1=0; DI2=0x10000.
- LDM with the base in the list: RLIST=0x0006, BASE_REG=2, WBACK=1 → R1 and R2 are loaded; no WEN2 in FIN.
- MREADY=0 for 3 cycles on the second beat → MREQ, MADDR and RA are held constant; DONE is delayed 3 cycles. A START pulsed during BUSY is ignored.
- RLIST=0 → DONE at cycle 1, no MREQ, no WEN2. Separately, nRST low during beat 2 of 4 → all outputs 0 at once, no DONE; a new START after release runs normally.
